// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory and
// hands each instruction word to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_load,
    output logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic [15:0] branch_label,
    output logic [25:0] jmp_label,
    output logic [31:0] instr_count,
    output logic        fetch_err
);

    // Handshake: a transfer happens on any rising edge where instr_valid and
    // decode_ready are both high; instr is stable while instr_valid is high.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        fetch_err_q, fetch_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        timeout;

    // An ack on the last allowed cycle wins over the timeout.
    assign timeout = (state_q == ST_FETCH) && !imem_ack && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_count_q <= 32'h0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= 8'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_count_q <= instr_count_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)     state_d = ST_HOLD;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_HOLD:  if (decode_ready) state_d = ST_WAIT;
            ST_WAIT:  if (pc_load)      state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = 8'h0;
                end else if (timeout) begin
                    fetch_err_d = 1'b1;
                    wait_cnt_d  = 8'h0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'h1;
                end
            end
            ST_HOLD: begin
                if (decode_ready) instr_count_d = instr_count_q + 32'h1;
            end
            ST_WAIT: begin
                if (pc_load) pc_d = next_pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
    end

    assign pc           = pc_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign branch_label = instr_q[15:0];
    assign jmp_label    = instr_q[25:0];
    assign instr_count  = instr_count_q;
    assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake, back-pressure, redirect,
// fetch timeout and reset during HOLD, with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_load;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        decode_ready;
    logic [15:0] branch_label;
    logic [25:0] jmp_label;
    logic [31:0] instr_count;
    logic        fetch_err;

    int n_cmp;
    int n_bad;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc      (next_pc),
        .pc_load      (pc_load),
        .pc           (pc),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .branch_label (branch_label),
        .jmp_label    (jmp_label),
        .instr_count  (instr_count),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        next_pc      = 32'h0;
        pc_load      = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        decode_ready = 1'b0;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_err", {31'h0, fetch_err}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);

        // First instruction: zero-wait ack, decode ready immediately.
        rst          = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'h2000_0047;
        decode_ready = 1'b1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        step();
        check("f1_req", {31'h0, imem_req}, 32'h1);
        check("f1_addr", imem_addr, 32'h0);
        step();
        check("h1_instr", instr, 32'h2000_0047);
        check("h1_valid", {31'h0, instr_valid}, 32'h1);
        check("h1_branch", {16'h0, branch_label}, 32'h0000_0047);
        check("h1_jmp", {6'h0, jmp_label}, 32'h0000_0047);
        check("h1_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b0;
        step();
        check("w1_count", instr_count, 32'h1);
        check("w1_valid", {31'h0, instr_valid}, 32'h0);

        // WAIT holds without pc_load, then redirect to 1045.
        step();
        check("w1_hold_pc", pc, 32'h0);
        check("w1_hold_req", {31'h0, imem_req}, 32'h0);
        next_pc = 32'd1045;
        pc_load = 1'b1;
        step();
        check("redir_pc", pc, 32'd1045);
        check("redir_addr", imem_addr, 32'd1045);
        check("redir_req", {31'h0, imem_req}, 32'h1);

        // Back-pressure with a stray pc_load pulse during HOLD.
        pc_load      = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        decode_ready = 1'b0;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h1111_1111;
        next_pc    = 32'd999;
        for (int i = 0; i < 5; i++) begin
            pc_load = (i == 2);
            check("bp_valid", {31'h0, instr_valid}, 32'h1);
            check("bp_instr", instr, 32'hDEAD_BEEF);
            check("bp_pc", pc, 32'd1045);
            step();
        end
        pc_load = 1'b0;
        check("bp_last_valid", {31'h0, instr_valid}, 32'h1);
        check("bp_pc_after", pc, 32'd1045);
        decode_ready = 1'b1;
        step();
        check("w2_count", instr_count, 32'h2);

        // Ack arriving on the final allowed cycle wins over the timeout.
        next_pc = 32'd2000;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_req", {31'h0, imem_req}, 32'h1);
            step();
        end
        check("late_ack_req4", {31'h0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0C00_1234;
        step();
        imem_ack = 1'b0;
        check("late_ack_instr", instr, 32'h0C00_1234);
        check("late_ack_valid", {31'h0, instr_valid}, 32'h1);
        check("late_ack_branch", {16'h0, branch_label}, 32'h0000_1234);
        check("late_ack_jmp", {6'h0, jmp_label}, 32'h0000_1234);
        check("late_ack_err", {31'h0, fetch_err}, 32'h0);
        step();
        check("w3_count", instr_count, 32'h3);

        // Memory never acks: four request cycles, one gap, then reissue.
        next_pc = 32'd3000;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req", {31'h0, imem_req}, 32'h1);
            check("to_addr", imem_addr, 32'd3000);
            check("to_err_clear", {31'h0, fetch_err}, 32'h0);
            step();
        end
        check("to_gap_req", {31'h0, imem_req}, 32'h0);
        check("to_err_set", {31'h0, fetch_err}, 32'h1);
        check("to_gap_pc", pc, 32'd3000);
        step();
        check("to_reissue_req", {31'h0, imem_req}, 32'h1);
        check("to_reissue_addr", imem_addr, 32'd3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_ABCD;
        decode_ready = 1'b0;
        step();
        check("to_hold_valid", {31'h0, instr_valid}, 32'h1);
        check("to_hold_count", instr_count, 32'h3);
        check("to_err_sticky", {31'h0, fetch_err}, 32'h1);

        // Reset in HOLD abandons the handshake; a late ack is ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hrst_pc", pc, 32'h0);
        check("hrst_count", instr_count, 32'h0);
        check("hrst_valid", {31'h0, instr_valid}, 32'h0);
        check("hrst_err", {31'h0, fetch_err}, 32'h0);
        check("hrst_instr", instr, 32'h0);
        check("hrst_req", {31'h0, imem_req}, 32'h0);
        step();
        check("hrst_instr_kept", instr, 32'h0);
        check("hrst_fetch_req", {31'h0, imem_req}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the architectural PC register and feeds `next_address`.
- Presents `pc` to instruction memory and to `next_address`, then latches the returned instruction word.
- Hands the instruction to decode over a valid/ready handshake.
- Exposes `branch_label` and `jmp_label` fields to `next_address`, and loads that block's `incr_pc` back into the PC when control signals instruction completion.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, cycles `imem_req` may stay unacknowledged before a fetch timeout (legal range 2..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- next_pc  in  32  next PC, driven by `next_address.incr_pc`.
- pc_load  in  1  control: current instruction finished, take `next_pc`.
- pc  out  32  current PC, to `imem_addr` and `next_address.pc`.
- imem_addr  out  32  memory address; combinationally equal to `pc`.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_ack  in  1  memory has valid data on `imem_rdata` this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  latched instruction register.
- instr_valid  out  1  `instr` offered to decode; high only in HOLD.
- decode_ready  in  1  decode accepts `instr`.
- branch_label  out  16  `instr[15:0]`, combinational.
- jmp_label  out  26  `instr[25:0]`, combinational.
- instr_count  out  32  number of instructions accepted by decode.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (rst high at posedge) has priority over every other input. It sets:
  - state=IDLE, pc=RESET_PC, instr=0, instr_count=0, fetch_err=0, wait_cnt=0.
  - Outputs in IDLE are therefore `imem_req`=0 and `instr_valid`=0.
- Reset mid-fetch or mid-handshake abandons the transaction; a late `imem_ack` is ignored.
- State machine (4 states, registered state):
  - IDLE: go to FETCH next cycle unconditionally.
  - FETCH: `imem_req`=1.
    - If `imem_ack` is sampled high: `instr`<=`imem_rdata`, wait_cnt<=0, go to HOLD. Zero-wait ack (same cycle `imem_req` first rises) is legal.
    - Else wait_cnt<=wait_cnt+1.
  - HOLD: `instr_valid`=1; `instr` held stable.
    - If `decode_ready` is high: instr_count<=instr_count+1 (wraps 2^32-1 -> 0), go to WAIT.
    - `decode_ready` arriving in the same cycle `instr_valid` first rises completes the handshake.
  - WAIT: if `pc_load` is high: pc<=`next_pc`, go to FETCH. Otherwise hold.
- `pc_load` is ignored in IDLE, FETCH and HOLD. `pc` changes only in WAIT or on reset.
- Fetch timeout:
  - Trigger: in FETCH with wait_cnt==MAX_WAIT-1 and `imem_ack` low.
  - Action: fetch_err<=1, wait_cnt<=0, go to IDLE. `imem_req` drops for exactly one cycle, then FETCH reissues the same `pc`.
  - `fetch_err` stays set until `rst`.
  - If `imem_ack` is high on the timeout cycle, the ack wins: normal capture, no error.
- `pc` and `next_pc` are passed through verbatim; no alignment check and no arithmetic in this block.
- Minimum loop: FETCH(ack) -> HOLD(ready) -> WAIT(load) = 3 cycles per instruction.

Test Plan:
- Reset release with RESET_PC=0, memory acks in first FETCH cycle with 32'h2000_0047, `decode_ready`=1:
  - IDLE one cycle, then `imem_req`=1 with `imem_addr`=0.
  - Next cycle: `instr`=32'h2000_0047, `instr_valid`=1, `branch_label`=16'h0047, `jmp_label`=26'h000_0047.
  - Following cycle: `instr_count`=1.
- Back-pressure: `decode_ready` low for 5 cycles -> `instr_valid` and `instr` held stable throughout; `pc_load` pulsed during HOLD is ignored (`pc` unchanged).
- Redirect: in WAIT, `next_pc`=1045 with `pc_load`=1 -> next cycle `pc`=1045, `imem_addr`=1045, `imem_req`=1.
- Timeout: MAX_WAIT=4, memory never acks -> `imem_req` high 4 cycles, low 1 cycle, high again with the same address; `fetch_err`=1 from the cycle after the 4th request cycle.
- Ack on the timeout cycle (MAX_WAIT=4, ack in 4th cycle) -> instruction captured, `fetch_err` stays 0.
- `rst` asserted in HOLD with `instr_count`=3 -> next cycle `pc`=RESET_PC, `instr_count`=0, `instr_valid`=0, `fetch_err`=0.
